cfu_ctrl: RTL and testbench



---
 rtl/cfu_ctrl_if.sv | 30 +++
 rtl/cfu_ctrl.sv | 132 +++++++++++++
 tb/tb_cfu_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_ctrl_if.sv
// CFU issue-port and execution-unit signal bundle for cfu_ctrl.
// slave: the controller; master: the CPU plus attached units (or a bench).
interface cfu_ctrl_if #(
  parameter int N_UNITS = 4
);
  logic                    en_i;
  logic [2:0]              funct3_i;
  logic [6:0]              funct7_i;
  logic [31:0]             src1_i;
  logic [31:0]             src2_i;
  logic                    stall_o;
  logic [31:0]             rslt_o;
  logic [N_UNITS-1:0]      u_start_o;
  logic [6:0]              u_funct7_o;
  logic [31:0]             u_src1_o;
  logic [31:0]             u_src2_o;
  logic [N_UNITS-1:0]      u_done_i;
  logic [32*N_UNITS-1:0]   u_rslt_i;
  logic                    err_o;

  modport slave (
    input  en_i, funct3_i, funct7_i, src1_i, src2_i, u_done_i, u_rslt_i,
    output stall_o, rslt_o, u_start_o, u_funct7_o, u_src1_o, u_src2_o, err_o
  );

  modport master (
    output en_i, funct3_i, funct7_i, src1_i, src2_i, u_done_i, u_rslt_i,
    input  stall_o, rslt_o, u_start_o, u_funct7_o, u_src1_o, u_src2_o, err_o
  );
endinterface

// File: rtl/cfu_ctrl.sv
// Sequencing controller between the CPU CFU issue port and N_UNITS
// variable-latency execution units.
//
// state | meaning
// IDLE  | waiting for a valid op; stall asserted combinationally on accept
// BUSY  | unit started (first cycle only); waiting for done or timeout
// DONE  | one cycle; result presented, CPU retires the instruction
module cfu_ctrl #(
  parameter int N_UNITS = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  cfu_ctrl_if.slave bus
);
  localparam int SEL_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rslt_q, rslt_d;
  logic               err_q, err_d;
  logic [N_UNITS-1:0] start_q, start_d;
  logic [6:0]         funct7_q, funct7_d;
  logic [31:0]        src1_q, src1_d;
  logic [31:0]        src2_q, src2_d;

  logic               valid_op;
  logic               done_sel;
  logic [31:0]        rslt_sel;

  assign valid_op = bus.en_i && ({29'd0, bus.funct3_i} < 32'(N_UNITS));

  // Pick out done and result of the selected unit; other units are ignored.
  always_comb begin
    done_sel = 1'b0;
    rslt_sel = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        done_sel = bus.u_done_i[k];
        rslt_sel = bus.u_rslt_i[32*k +: 32];
      end
    end
  end

  // Next-state and datapath updates; start is only ever a one-cycle pulse.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    rslt_d   = rslt_q;
    err_d    = err_q;
    start_d  = '0;
    funct7_d = funct7_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    case (state_q)
      IDLE: begin
        if (valid_op) begin
          funct7_d = bus.funct7_i;
          src1_d   = bus.src1_i;
          src2_d   = bus.src2_i;
          sel_d    = bus.funct3_i[SEL_W-1:0];
          cnt_d    = '0;
          for (int k = 0; k < N_UNITS; k++) begin
            start_d[k] = (bus.funct3_i == 3'(k));
          end
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // done has priority over a timeout landing in the same cycle
        if (done_sel) begin
          rslt_d  = rslt_sel;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rslt_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register everything; synchronous reset discards any in-flight op.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      rslt_q   <= '0;
      err_q    <= 1'b0;
      start_q  <= '0;
      funct7_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      rslt_q   <= rslt_d;
      err_q    <= err_d;
      start_q  <= start_d;
      funct7_q <= funct7_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
    end
  end

  assign bus.stall_o    = ((state_q == IDLE) && valid_op) || (state_q == BUSY);
  assign bus.rslt_o     = (state_q == DONE) ? rslt_q : 32'd0;
  assign bus.u_start_o  = start_q;
  assign bus.u_funct7_o = funct7_q;
  assign bus.u_src1_o   = src1_q;
  assign bus.u_src2_o   = src2_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_cfu_ctrl.sv
// Scoreboard bench for cfu_ctrl: dut_a uses the default timeout, dut_b a
// short timeout of 4. Each retirement (en_i=1, stall_o=0) is checked
// against the expected entry pushed when the op was issued.
module tb_cfu_ctrl;
  typedef struct {
    logic [31:0] rslt;
    logic        err;
    int          stalls;
    logic [3:0]  start;
    int          nstart;
    bit          chk_ops;
    logic [6:0]  f7;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int nchecks = 0;
  int nerrors = 0;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          lat_a[4];
  int          lat_b[4];
  logic [31:0] val_a[4];
  logic [31:0] val_b[4];
  int          acc_stall[2];
  logic [3:0]  acc_start[2];
  int          acc_nstart[2];

  always #5 clk = ~clk;

  cfu_ctrl_if #(.N_UNITS(4)) bus_a ();
  cfu_ctrl_if #(.N_UNITS(4)) bus_b ();

  cfu_ctrl #(.N_UNITS(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a.slave)
  );

  cfu_ctrl #(.N_UNITS(4), .TIMEOUT(4), .CNT_W(3)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic e, input int st,
                              input logic [3:0] sm, input int ns, input bit co,
                              input logic [6:0] f7, input logic [31:0] s1,
                              input logic [31:0] s2);
    exp_t x;
    x.rslt = r; x.err = e; x.stalls = st; x.start = sm; x.nstart = ns;
    x.chk_ops = co; x.f7 = f7; x.s1 = s1; x.s2 = s2;
    return x;
  endfunction

  task automatic mon_step(input int id, input logic rst, input logic en, input logic stall,
                          input logic [31:0] rslt, input logic err, input logic [3:0] start,
                          input logic [6:0] f7, input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    int   qs;
    if (rst) begin
      acc_stall[id] = 0; acc_start[id] = '0; acc_nstart[id] = 0;
    end else begin
      if (start != 4'd0) begin
        acc_start[id] = acc_start[id] | start;
        acc_nstart[id]++;
      end
      if (en && stall) begin
        acc_stall[id]++;
      end else if (en && !stall) begin
        qs = (id == 0) ? exp_q0.size() : exp_q1.size();
        if (qs == 0) begin
          nchecks++; nerrors++;
          $display("FAIL unexpected_retire dut%0d: got retire rslt 0x%08h, expected none", id, rslt);
        end else begin
          if (id == 0) e = exp_q0.pop_front();
          else         e = exp_q1.pop_front();
          chk($sformatf("rslt dut%0d", id), rslt, e.rslt);
          chk($sformatf("err dut%0d", id), {31'd0, err}, {31'd0, e.err});
          chk($sformatf("stall_cycles dut%0d", id), 32'(acc_stall[id]), 32'(e.stalls));
          chk($sformatf("start_mask dut%0d", id), {28'd0, acc_start[id]}, {28'd0, e.start});
          chk($sformatf("start_cycles dut%0d", id), 32'(acc_nstart[id]), 32'(e.nstart));
          if (e.chk_ops) begin
            chk($sformatf("u_funct7 dut%0d", id), {25'd0, f7}, {25'd0, e.f7});
            chk($sformatf("u_src1 dut%0d", id), s1, e.s1);
            chk($sformatf("u_src2 dut%0d", id), s2, e.s2);
          end
        end
        acc_stall[id] = 0; acc_start[id] = '0; acc_nstart[id] = 0;
      end
    end
  endtask

  // Monitor: sample both DUTs on the falling edge
  always @(negedge clk) begin
    mon_step(0, rst_a, bus_a.en_i, bus_a.stall_o, bus_a.rslt_o, bus_a.err_o, bus_a.u_start_o,
             bus_a.u_funct7_o, bus_a.u_src1_o, bus_a.u_src2_o);
    mon_step(1, rst_b, bus_b.en_i, bus_b.stall_o, bus_b.rslt_o, bus_b.err_o, bus_b.u_start_o,
             bus_b.u_funct7_o, bus_b.u_src1_o, bus_b.u_src2_o);
  end

  // Unit model: on a start, pulse done after lat cycles (lat<0 = never)
  task automatic responder(input int id);
    int k;
    int l;
    forever begin
      @(negedge clk);
      k = -1;
      for (int i = 0; i < 4; i++) begin
        if (id == 0) begin
          if (bus_a.u_start_o[i] && !rst_a) k = i;
        end else begin
          if (bus_b.u_start_o[i] && !rst_b) k = i;
        end
      end
      if (k >= 0) begin
        l = (id == 0) ? lat_a[k] : lat_b[k];
        if (l >= 0) begin
          repeat (l) @(negedge clk);
          if (id == 0) begin
            bus_a.u_rslt_i[32*k +: 32] = val_a[k]; bus_a.u_done_i[k] = 1'b1;
          end else begin
            bus_b.u_rslt_i[32*k +: 32] = val_b[k]; bus_b.u_done_i[k] = 1'b1;
          end
          @(negedge clk);
          if (id == 0) bus_a.u_done_i[k] = 1'b0;
          else         bus_b.u_done_i[k] = 1'b0;
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge ending DONE
  task automatic op(input int id, input logic [2:0] f3, input logic [6:0] f7,
                    input logic [31:0] s1, input logic [31:0] s2, input exp_t e, input bit drop);
    bit fin;
    int n;
    fin = 1'b0;
    n = 0;
    if (id == 0) begin
      exp_q0.push_back(e);
      bus_a.en_i = 1'b1; bus_a.funct3_i = f3; bus_a.funct7_i = f7;
      bus_a.src1_i = s1; bus_a.src2_i = s2;
    end else begin
      exp_q1.push_back(e);
      bus_b.en_i = 1'b1; bus_b.funct3_i = f3; bus_b.funct7_i = f7;
      bus_b.src1_i = s1; bus_b.src2_i = s2;
    end
    while (!fin && n < 400) begin
      @(negedge clk);
      n++;
      fin = (id == 0) ? !bus_a.stall_o : !bus_b.stall_o;
    end
    if (!fin) begin
      nchecks++; nerrors++;
      $display("FAIL op_wait dut%0d: got no retire after %0d cycles, expected retire", id, n);
    end
    @(posedge clk);
    #1;
    if (drop) begin
      if (id == 0) bus_a.en_i = 1'b0;
      else         bus_b.en_i = 1'b0;
    end
  endtask

  initial begin
    fork
      responder(0);
      responder(1);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.en_i = 1'b0; bus_a.funct3_i = '0; bus_a.funct7_i = '0;
    bus_a.src1_i = '0; bus_a.src2_i = '0; bus_a.u_done_i = '0; bus_a.u_rslt_i = '0;
    bus_b.en_i = 1'b0; bus_b.funct3_i = '0; bus_b.funct7_i = '0;
    bus_b.src1_i = '0; bus_b.src2_i = '0; bus_b.u_done_i = '0; bus_b.u_rslt_i = '0;
    for (int i = 0; i < 4; i++) begin
      lat_a[i] = 0; lat_b[i] = 0; val_a[i] = '0; val_b[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("reset stall_a", {31'd0, bus_a.stall_o}, 32'd0);
    chk("reset rslt_a", bus_a.rslt_o, 32'd0);
    chk("reset err_a", {31'd0, bus_a.err_o}, 32'd0);
    chk("reset start_a", {28'd0, bus_a.u_start_o}, 32'd0);
    chk("reset src1_a", bus_a.u_src1_o, 32'd0);
    chk("reset funct7_a", {25'd0, bus_a.u_funct7_o}, 32'd0);
    chk("reset err_b", {31'd0, bus_b.err_o}, 32'd0);
    chk("reset rslt_b", bus_b.rslt_o, 32'd0);
    @(posedge clk);
    #1;

    // zero-wait unit 1
    lat_a[1] = 0; val_a[1] = 32'h0000000C;
    op(0, 3'd1, 7'h20, 32'd5, 32'd7, mk(32'h0000000C, 1'b0, 2, 4'b0010, 1, 1'b1, 7'h20, 32'd5, 32'd7), 1'b1);
    @(negedge clk);
    chk("rslt_after_done", bus_a.rslt_o, 32'd0);
    chk("start_after_done", {28'd0, bus_a.u_start_o}, 32'd0);
    @(posedge clk);
    #1;

    // slow unit 2: done 9 cycles after the start cycle -> 11 stall cycles
    lat_a[2] = 9; val_a[2] = 32'hDEADBEEF;
    op(0, 3'd2, 7'h01, 32'h100, 32'h200, mk(32'hDEADBEEF, 1'b0, 11, 4'b0100, 1, 1'b1, 7'h01, 32'h100, 32'h200), 1'b1);

    // invalid funct3 (6 and boundary 4): immediate retire, operands unchanged
    op(0, 3'd6, 7'h7F, 32'h99, 32'h98, mk(32'd0, 1'b0, 0, 4'b0000, 0, 1'b1, 7'h01, 32'h100, 32'h200), 1'b1);
    op(0, 3'd4, 7'h7E, 32'h97, 32'h96, mk(32'd0, 1'b0, 0, 4'b0000, 0, 1'b1, 7'h01, 32'h100, 32'h200), 1'b1);

    // spurious done on unit 3 while unit 1 is busy
    lat_a[1] = 4; val_a[1] = 32'h11112222;
    fork
      op(0, 3'd1, 7'h05, 32'hA, 32'hB, mk(32'h11112222, 1'b0, 6, 4'b0010, 1, 1'b1, 7'h05, 32'hA, 32'hB), 1'b1);
      begin
        repeat (2) @(negedge clk);
        bus_a.u_rslt_i[127:96] = 32'hBAD0BAD0;
        bus_a.u_done_i[3] = 1'b1;
        @(negedge clk);
        bus_a.u_done_i[3] = 1'b0;
      end
    join

    // back-to-back: unit 0 then unit 3
    lat_a[0] = 2; val_a[0] = 32'h00000A0A;
    lat_a[3] = 1; val_a[3] = 32'h33330003;
    op(0, 3'd0, 7'h10, 32'd1, 32'd2, mk(32'h00000A0A, 1'b0, 4, 4'b0001, 1, 1'b1, 7'h10, 32'd1, 32'd2), 1'b0);
    op(0, 3'd3, 7'h33, 32'd3, 32'd4, mk(32'h33330003, 1'b0, 3, 4'b1000, 1, 1'b1, 7'h33, 32'd3, 32'd4), 1'b1);

    // reset in the 3rd BUSY cycle of a unit that never answers
    lat_a[3] = -1;
    bus_a.en_i = 1'b1; bus_a.funct3_i = 3'd3; bus_a.funct7_i = 7'h44;
    bus_a.src1_i = 32'h55; bus_a.src2_i = 32'h66;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_before_reset", {31'd0, bus_a.stall_o}, 32'd1);
    rst_a = 1'b1;
    bus_a.en_i = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(negedge clk);
    chk("post_reset stall", {31'd0, bus_a.stall_o}, 32'd0);
    chk("post_reset rslt", bus_a.rslt_o, 32'd0);
    chk("post_reset err", {31'd0, bus_a.err_o}, 32'd0);
    chk("post_reset start", {28'd0, bus_a.u_start_o}, 32'd0);
    chk("post_reset src1", bus_a.u_src1_o, 32'd0);
    @(posedge clk);
    #1;
    lat_a[0] = 0; val_a[0] = 32'h00000005;
    op(0, 3'd0, 7'h02, 32'h8, 32'h9, mk(32'h00000005, 1'b0, 2, 4'b0001, 1, 1'b1, 7'h02, 32'h8, 32'h9), 1'b1);

    // dut_b: done on the last allowed BUSY cycle wins over timeout
    lat_b[2] = 3; val_b[2] = 32'h00002222;
    op(1, 3'd2, 7'h02, 32'hA, 32'hB, mk(32'h00002222, 1'b0, 5, 4'b0100, 1, 1'b1, 7'h02, 32'hA, 32'hB), 1'b1);

    // dut_b: unit 0 never responds
    lat_b[0] = -1;
    op(1, 3'd0, 7'h00, 32'h1, 32'h1, mk(32'd0, 1'b1, 5, 4'b0001, 1, 1'b1, 7'h00, 32'h1, 32'h1), 1'b1);

    // late done from unit 0 in IDLE is ignored
    bus_b.u_rslt_i[31:0] = 32'h0000FFFF;
    bus_b.u_done_i[0] = 1'b1;
    @(negedge clk);
    chk("late_done stall", {31'd0, bus_b.stall_o}, 32'd0);
    chk("late_done rslt", bus_b.rslt_o, 32'd0);
    chk("late_done err", {31'd0, bus_b.err_o}, 32'd1);
    @(posedge clk);
    #1;
    bus_b.u_done_i[0] = 1'b0;
    @(negedge clk);
    chk("after_late rslt", bus_b.rslt_o, 32'd0);
    @(posedge clk);
    #1;

    // err stays set across a later good op
    lat_b[1] = 1; val_b[1] = 32'h00000077;
    op(1, 3'd1, 7'h03, 32'h2, 32'h3, mk(32'h00000077, 1'b1, 3, 4'b0010, 1, 1'b1, 7'h03, 32'h2, 32'h3), 1'b1);

    repeat (3) @(posedge clk);
    chk("pending_a", 32'(exp_q0.size()), 32'd0);
    chk("pending_b", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
